// File: rtl/morse_pkg.sv
// Shared types and timing constants for the Morse digit keyer.
package morse_pkg;

  typedef enum logic [1:0] {IDLE, MARK, SPACE, GAP} state_t;

  // Bit 4 goes out first; 1 = dot, 0 = dash.
  typedef logic [4:0] pattern_t;

  localparam logic [1:0] DOT_UNITS   = 2'd1;
  localparam logic [1:0] DASH_UNITS  = 2'd3;
  localparam logic [1:0] SPACE_UNITS = 2'd1;
  localparam logic [1:0] GAP_UNITS   = 2'd2;

  localparam logic [2:0] SYMS_PER_CHAR = 3'd5;

endpackage

// File: rtl/morse_keyer_if.sv
// Digit handshake between the switch/button logic and the keyer.
interface morse_keyer_if;
  logic       in_valid;
  logic [3:0] in_digit;
  logic       in_ready;

  modport master (output in_valid, output in_digit, input  in_ready);
  modport slave  (input  in_valid, input  in_digit, output in_ready);
endinterface

// File: rtl/morse_symbol_rom.sv
// Digit to 5-symbol Morse pattern lookup; digits above 9 flag invalid.
module morse_symbol_rom
  import morse_pkg::*;
(
  input  logic [3:0] digit,
  output pattern_t   pattern,
  output logic       invalid
);

  always_comb begin
    pattern = '0;
    invalid = 1'b0;
    case (digit)
      4'd0:    pattern = 5'b00000;
      4'd1:    pattern = 5'b10000;
      4'd2:    pattern = 5'b11000;
      4'd3:    pattern = 5'b11100;
      4'd4:    pattern = 5'b11110;
      4'd5:    pattern = 5'b11111;
      4'd6:    pattern = 5'b01111;
      4'd7:    pattern = 5'b00111;
      4'd8:    pattern = 5'b00011;
      4'd9:    pattern = 5'b00001;
      default: invalid = 1'b1;
    endcase
  end

endmodule

// File: rtl/morse_keyer.sv
// Timed serial Morse transmitter for one decimal digit per handshake.
// Define MORSE_KEYER_CHAR_GAP_EN to append the 2-unit inter-character gap.
module morse_keyer
  import morse_pkg::*;
#(
  parameter int UNIT_CYCLES = 12_500_000
) (
  input  logic          clk,
  input  logic          reset_n,
  morse_keyer_if.slave  in_if,
  input  logic          abort,
  output logic          key_out,
  output logic          busy,
  output logic [2:0]    sym_idx,
  output logic          done,
  output logic          err
);

  localparam int CNT_W = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(UNIT_CYCLES - 1);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [1:0]       units, units_n, len;
  logic [2:0]       sym_n;
  pattern_t         pat, pat_n, rom_pat;
  logic             rom_invalid, hs, tick, last_unit, err_n;

  morse_symbol_rom u_rom (
    .digit   (in_if.in_digit),
    .pattern (rom_pat),
    .invalid (rom_invalid)
  );

  assign in_if.in_ready = (state == IDLE);
  assign busy           = (state != IDLE);
  assign hs             = in_if.in_valid & in_if.in_ready;
  assign tick           = (cnt == CNT_LAST);

  always_comb begin
    len = DOT_UNITS;
    case (state)
      MARK:    len = pat[3'd4 - sym_idx] ? DOT_UNITS : DASH_UNITS;
      SPACE:   len = SPACE_UNITS;
      GAP:     len = GAP_UNITS;
      default: len = DOT_UNITS;
    endcase
  end

  assign last_unit = tick && (units == len - 2'd1);

  always_comb begin
    state_n = state;
    cnt_n   = tick ? '0 : cnt + CNT_W'(1);
    units_n = tick ? units + 2'd1 : units;
    sym_n   = sym_idx;
    pat_n   = pat;
    err_n   = 1'b0;
    done    = 1'b0;
    case (state)
      IDLE: begin
        cnt_n   = '0;
        units_n = '0;
        if (hs) begin
          if (rom_invalid) begin
            err_n = 1'b1;
          end else begin
            state_n = MARK;
            pat_n   = rom_pat;
            sym_n   = '0;
          end
        end
      end
      MARK: if (last_unit) state_n = SPACE;
      SPACE: begin
        if (last_unit) begin
          if (sym_idx < SYMS_PER_CHAR - 3'd1) begin
            sym_n   = sym_idx + 3'd1;
            state_n = MARK;
          end else begin
`ifdef MORSE_KEYER_CHAR_GAP_EN
            state_n = GAP;
`else
            state_n = IDLE;
            sym_n   = '0;
            done    = 1'b1;
`endif
          end
        end
      end
      GAP: begin
        if (last_unit) begin
          state_n = IDLE;
          sym_n   = '0;
          done    = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    // Abort only cancels a character in flight; an IDLE handshake takes priority.
    if (state != IDLE && abort) begin
      state_n = IDLE;
      sym_n   = '0;
      done    = 1'b0;
    end
    if (state_n != state) begin
      cnt_n   = '0;
      units_n = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      cnt     <= '0;
      units   <= '0;
      sym_idx <= '0;
      key_out <= 1'b0;
      err     <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      units   <= units_n;
      sym_idx <= sym_n;
      key_out <= (state_n == MARK);
      err     <= err_n;
    end
  end

  always_ff @(posedge clk) begin
    pat <= pat_n;
  end

endmodule
